// File: rtl/cmd_pkg.sv
// Shared types and sizes for the command framer: receive states and frame geometry.
package cmd_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned FRAME_BYTES = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    WAIT_LO = 2'd2
  } rx_state_e;

endpackage

// File: rtl/cmd_framer_if.sv
// Signal bundle between the framer and its UART/downstream neighbours.
interface cmd_framer_if;
  import cmd_pkg::*;

  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rx_rdy;
  logic              cmd_rdy;
  logic [BYTE_W-1:0] cmd;
  logic [DATA_W-1:0] data;
  logic              clr_cmd_rdy;
  logic [BYTE_W-1:0] resp;
  logic              send_resp;
  logic [BYTE_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic              tx_busy;
  logic              frm_err;

  // Framer side
  modport slave (
    input  rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    output clr_rx_rdy, cmd_rdy, cmd, data, tx_data, trmt, tx_busy, frm_err
  );

  // Environment side (UART + command consumer)
  modport master (
    output rx_rdy, rx_data, clr_cmd_rdy, resp, send_resp, tx_done,
    input  clr_rx_rdy, cmd_rdy, cmd, data, tx_data, trmt, tx_busy, frm_err
  );

endinterface

// File: rtl/frm_timer.sv
// Inter-byte silence counter; tmo flags the last allowed idle cycle of a partial frame.
module frm_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tmo
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  // A byte arriving in the would-be timeout cycle suppresses the timeout
  assign tmo = en & ~clr & (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || clr || !en || tmo) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_framer.sv
// Assembles 3-byte command frames from a UART receiver and launches single-byte responses.
module cmd_framer
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              clr_rx_rdy,
  output logic              cmd_rdy,
  output logic [BYTE_W-1:0] cmd,
  output logic [DATA_W-1:0] data,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic [BYTE_W-1:0] tx_data,
  output logic              trmt,
  input  logic              tx_done,
  output logic              tx_busy,
  output logic              frm_err
);

  rx_state_e state;
  logic      cap;
  logic      tmr_en;
  logic      tmo;

  // Every offered byte is consumed immediately, whatever the state
  assign cap        = rx_rdy & ~rst;
  assign clr_rx_rdy = cap;
  assign tmr_en     = (state != IDLE);

  frm_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (cap),
    .en  (tmr_en),
    .tmo (tmo)
  );

  // Receive FSM with registered frame outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd     <= '0;
      data    <= '0;
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (cap) begin
        unique case (state)
          IDLE: begin
            cmd     <= rx_data;
            cmd_rdy <= 1'b0;
            state   <= WAIT_HI;
          end
          WAIT_HI: begin
            data[DATA_W-1:BYTE_W] <= rx_data;
            state                 <= WAIT_LO;
          end
          WAIT_LO: begin
            data[BYTE_W-1:0] <= rx_data;
            cmd_rdy          <= 1'b1;
            state            <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tmo) begin
        state   <= IDLE;
        frm_err <= 1'b1;
      end
    end
  end

  // Response transmit path; a send in the tx_done cycle chains straight into a new byte
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data <= '0;
      trmt    <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      trmt <= 1'b0;
      if (send_resp && (!tx_busy || tx_done)) begin
        tx_data <= resp;
        trmt    <= 1'b1;
        tx_busy <= 1'b1;
      end else if (tx_done) begin
        tx_busy <= 1'b0;
      end
    end
  end

endmodule
